// File: rtl/mant_recip_nr.sv
// Mantissa reciprocal: a table seed is registered, then one combinational Newton-Raphson step
// gives x1 = x0*(2 - num*x0), truncated to 1.(2*MS-1). One cycle of latency and one result per cycle.
module mant_recip_nr #(
  parameter int MS      = 14,
  parameter int LUT_IN  = 8,
  parameter int LUT_OUT = 2*LUT_IN+4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [MS-1:0]   num,
  output logic [2*MS-1:0] x1
);

  localparam int X0W = 3*MS-4;          // seed format 1.(3*MS-5)
  localparam int FW  = X0W-1;           // seed fraction width
  localparam int DW  = MS+X0W;          // num*x0 and 2-p, format 2.(4*MS-6)
  localparam int PW  = X0W+DW;          // x0*d, format 3.(7*MS-11)
  localparam int SH  = (FW+DW-2)-(2*MS-1);

  localparam logic [DW-1:0] TWO = {2'b10, {(DW-2){1'b0}}};

  // Seed table: reciprocal of each interval midpoint, left-aligned in the seed fraction.
  logic [FW-1:0] lut [2**LUT_IN];

  for (genvar g = 0; g < 2**LUT_IN; g++) begin : g_lut
    localparam logic [63:0] ENT = (64'd1 << (LUT_OUT+LUT_IN+1)) /
                                  ((64'd1 << (LUT_IN+1)) + 64'(2*g+1));
    if (LUT_OUT <= FW) begin : g_shl
      assign lut[g] = FW'(ENT << (FW-LUT_OUT));
    end else begin : g_shr
      assign lut[g] = FW'(ENT >> (LUT_OUT-FW));
    end
  end

  logic [LUT_IN-1:0] idx;

  if (MS-1 >= LUT_IN) begin : g_idx_full
    assign idx = num[MS-2 -: LUT_IN];
  end else begin : g_idx_pad
    assign idx = {num[MS-2:0], {(LUT_IN-MS+1){1'b0}}};
  end

  logic [MS-1:0]  num_d, num_q;
  logic [X0W-1:0] x0_d, x0_q;

  always_comb begin
    // The incoming unit bit is ignored: every input is taken as normalized.
    num_d = {num[MS-1] | 1'b1, num[MS-2:0]};
    x0_d  = {1'b0, lut[idx]};
    if (num[MS-2:0] == '0) begin
      x0_d = {1'b1, {(X0W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= '0;
      x0_q  <= '0;
    end else begin
      num_q <= num_d;
      x0_q  <= x0_d;
    end
  end

  logic [DW-1:0] p;
  logic [DW-1:0] d;
  logic [PW-1:0] prod;

  always_comb begin
    p    = DW'(num_q) * DW'(x0_q);
    d    = TWO - p;
    prod = PW'(x0_q) * PW'(d);
    // Cleared registers give p = 0, d = 2 and x0 = 0, so x1 reads 0 after reset.
    x1   = (2*MS)'(prod >> SH);
  end

endmodule

// File: tb/tb_mant_recip_nr.sv
// Directed bench for mant_recip_nr at default parameters (MS=14): reset, unity, corner values,
// a full back-to-back mantissa sweep and a reset pulse in the middle of a stream.
module tb_mant_recip_nr;

  localparam int MS = 14;

  logic            clk;
  logic            rst;
  logic [MS-1:0]   num;
  logic [2*MS-1:0] x1;

  int test_cnt = 0;
  int fail_cnt = 0;

  mant_recip_nr dut (
    .clk (clk),
    .rst (rst),
    .num (num),
    .x1  (x1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present inputs, then step to just after the capturing edge so x1 reflects them.
  task automatic cycle_in(input logic [MS-1:0] n, input logic r);
    num = n;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [2*MS-1:0] exp);
    test_cnt++;
    assert (x1 === exp)
    else begin
      fail_cnt++;
      $error("FAIL %s got=%h exp=%h", tag, x1, exp);
    end
  endtask

  // Result must not exceed floor(2^40/n) and must be within 2048 LSB of it.
  task automatic check_rng(input string tag, input logic [MS-1:0] n);
    logic [63:0] ref_v;
    logic [63:0] got;
    logic        ok;
    ref_v = (64'd1 << 40) / 64'(n);
    got   = 64'(x1);
    ok    = (got <= ref_v) && ((ref_v - got) <= 64'd2048);
    test_cnt++;
    assert (ok === 1'b1)
    else begin
      fail_cnt++;
      $error("FAIL %s num=%h got=%h ref=%h", tag, n, x1, ref_v);
    end
  endtask

  task automatic check_ge(input string tag, input logic [2*MS-1:0] lo);
    test_cnt++;
    assert (x1 >= lo)
    else begin
      fail_cnt++;
      $error("FAIL %s got=%h min=%h", tag, x1, lo);
    end
  endtask

  initial begin
    num = 14'h3000;
    rst = 1'b1;

    // Reset held for two edges with a nonzero input.
    cycle_in(14'h3000, 1'b1);
    check_eq("reset_edge1", 28'h0);
    cycle_in(14'h3000, 1'b1);
    check_eq("reset_edge2", 28'h0);

    // Unity gives exactly 1.0.
    cycle_in(14'h2000, 1'b0);
    check_eq("unity", 28'h8000000);

    // 1.5 -> 2/3.
    cycle_in(14'h3000, 1'b0);
    check_rng("one_half", 14'h3000);
    check_ge("one_half_lo", 28'h5555555 - 28'd2048);
    test_cnt++;
    assert (x1 <= 28'h5555555)
    else begin
      fail_cnt++;
      $error("FAIL one_half_hi got=%h max=%h", x1, 28'h5555555);
    end

    // Largest mantissa: floor(2^40/0x3FFF) = 0x4001000.
    cycle_in(14'h3FFF, 1'b0);
    check_rng("max_mant", 14'h3FFF);
    check_ge("max_mant_lo", 28'h4000000);

    // Unit bit clear is treated as set.
    cycle_in(14'h1000, 1'b0);
    check_rng("unit_bit_ignored", 14'h3000);
    cycle_in(14'h0000, 1'b0);
    check_eq("unit_bit_unity", 28'h8000000);

    // Smallest non-unity mantissa and a table-boundary neighbour.
    cycle_in(14'h2001, 1'b0);
    check_rng("min_frac", 14'h2001);
    cycle_in(14'h203F, 1'b0);
    check_rng("seg_edge", 14'h203F);

    // Back-to-back sweep of every mantissa.
    for (int n = 14'h2000; n <= 14'h3FFF; n++) begin
      cycle_in(14'(n), 1'b0);
      check_rng("sweep", 14'(n));
    end

    // Reset pulse in mid-stream: exactly one zero output, then recovery.
    cycle_in(14'h2800, 1'b0);
    check_rng("pre_reset", 14'h2800);
    cycle_in(14'h2A00, 1'b1);
    check_eq("mid_reset", 28'h0);
    cycle_in(14'h2C00, 1'b0);
    check_rng("post_reset", 14'h2C00);
    cycle_in(14'h2000, 1'b0);
    check_eq("post_reset_unity", 28'h8000000);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
